sa_group_sequencer: RTL and testbench

- Top-level sequencer for the systolic array (SA) and its controller.
- Walks the per-filter-group configuration ROM, one address per group.
- For each group, drives the array through its reset → load → ready → start phase handshake and issues the weight and feature buffer read strobes.
- Sits between the host/job interface and the SA controller/array; the array datapath itself is unchanged.

---
 rtl/sa_group_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_sa_group_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sa_group_sequencer.sv
// sa_group_sequencer
// Top-level job sequencer for the systolic array. It walks the per-group
// configuration ROM and, for each filter group, steps the array through
// reset -> load -> ready -> start and issues the buffer read strobes.
// The outputs are decoded from the state register. The only exception is
// rd_feature_ld_o, which also depends on stall_i so that a feature-buffer
// underrun gates the strobe in the same cycle.
module sa_group_sequencer #(
    parameter int N_ROWS_ARRAY     = 4,
    parameter int N                = 3,
    parameter int SIG_ADDRS_WIDTH  = 10,
    parameter int STREAM_CNT_WIDTH = 16
) (
    input  logic                          clk_i,
    input  logic                          general_rst_i,
    input  logic                          start_i,
    input  logic [SIG_ADDRS_WIDTH-1:0]    num_groups_i,
    input  logic [$clog2(N+1)-1:0]        filter_size_i,
    input  logic [STREAM_CNT_WIDTH-1:0]   stream_len_i,
    input  logic                          stall_i,
    output logic                          rst_o,
    output logic                          load_o,
    output logic                          ready_o,
    output logic                          start_op_o,
    output logic                          rd_rom_signals_ld_o,
    output logic [SIG_ADDRS_WIDTH-1:0]    addrs_rom_signal_o,
    output logic                          rd_weight_ld_o,
    output logic                          rd_feature_ld_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int FS_W = $clog2(N+1);

    localparam logic [SIG_ADDRS_WIDTH-1:0]  ADDR_ONE   = SIG_ADDRS_WIDTH'(1);
    localparam logic [FS_W-1:0]             FS_ONE     = FS_W'(1);
    localparam logic [FS_W-1:0]             FS_ZERO    = '0;
    localparam logic [STREAM_CNT_WIDTH-1:0] STREAM_ONE = STREAM_CNT_WIDTH'(1);

    // The array row count does not affect sequencing. It stays a parameter
    // so the interface matches the array. This empty block only marks a
    // nonsensical row count at elaboration time.
    generate
        if (N_ROWS_ARRAY < 1) begin : g_rows_invalid
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_ARR_RST = 3'd2,
        S_LOAD    = 3'd3,
        S_READY   = 3'd4,
        S_RUN     = 3'd5,
        S_NEXT    = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t                         state_reg;
    state_t                         state_next;

    // Shadow copies of the job parameters. They are taken once in IDLE,
    // so input changes during a job have no effect on that job.
    logic [SIG_ADDRS_WIDTH-1:0]     groups_reg;
    logic [FS_W-1:0]                fsize_reg;
    logic [STREAM_CNT_WIDTH-1:0]    slen_reg;

    logic [SIG_ADDRS_WIDTH-1:0]     addr_reg;
    logic [SIG_ADDRS_WIDTH-1:0]     addr_next;
    logic [FS_W-1:0]                load_cnt_reg;
    logic [FS_W-1:0]                load_cnt_next;
    logic [STREAM_CNT_WIDTH-1:0]    beat_cnt_reg;
    logic [STREAM_CNT_WIDTH-1:0]    beat_cnt_next;

    logic                           job_accept;
    logic                           load_last;
    logic                           beat_last;
    logic                           group_last;
    logic [FS_W-1:0]                load_last_idx;

    // A filter size of 0 still spends one cycle in LOAD. The last LOAD
    // index is therefore max(F,1)-1.
    assign load_last_idx = (fsize_reg == FS_ZERO) ? FS_ZERO : (fsize_reg - FS_ONE);
    assign load_last     = (load_cnt_reg == load_last_idx);
    // A beat counts only when the feature buffer is not stalled. A stall
    // on the final beat therefore holds the FSM in RUN.
    assign beat_last     = !stall_i && ((beat_cnt_reg + STREAM_ONE) == slen_reg);
    // groups_reg is at least 1 whenever NEXT is reachable, so the
    // subtraction below cannot underflow.
    assign group_last    = (addr_reg == (groups_reg - ADDR_ONE));
    assign job_accept    = (state_reg == S_IDLE) && start_i;

    // State register: an asynchronous reset aborts any job in flight.
    always_ff @(posedge clk_i or negedge general_rst_i) begin
        if (!general_rst_i) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic for the group walk.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start_i) begin
                    state_next = (num_groups_i == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH:   state_next = S_ARR_RST;
            S_ARR_RST: state_next = S_LOAD;
            S_LOAD: begin
                if (load_last) begin
                    state_next = S_READY;
                end
            end
            S_READY: begin
                state_next = (slen_reg == '0) ? S_NEXT : S_RUN;
            end
            S_RUN: begin
                if (beat_last) begin
                    state_next = S_NEXT;
                end
            end
            S_NEXT: begin
                state_next = group_last ? S_DONE : S_FETCH;
            end
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Latch the job parameters when a new job is accepted.
    always_ff @(posedge clk_i or negedge general_rst_i) begin
        if (!general_rst_i) begin
            groups_reg <= '0;
            fsize_reg  <= '0;
            slen_reg   <= '0;
        end else if (job_accept) begin
            groups_reg <= num_groups_i;
            fsize_reg  <= filter_size_i;
            slen_reg   <= stream_len_i;
        end
    end

    // Group address: cleared at job start and advanced in NEXT. It is
    // never advanced past the last group, so it cannot wrap within a job.
    always_comb begin
        addr_next = addr_reg;
        if (job_accept) begin
            addr_next = '0;
        end else if ((state_reg == S_NEXT) && !group_last) begin
            addr_next = addr_reg + ADDR_ONE;
        end
    end

    // Group address register.
    always_ff @(posedge clk_i or negedge general_rst_i) begin
        if (!general_rst_i) begin
            addr_reg <= '0;
        end else begin
            addr_reg <= addr_next;
        end
    end

    // The weight-load counter runs only inside LOAD. It idles at zero so
    // that each group starts counting from zero.
    always_comb begin
        load_cnt_next = '0;
        if ((state_reg == S_LOAD) && !load_last) begin
            load_cnt_next = load_cnt_reg + FS_ONE;
        end
    end

    // The feature-beat counter advances on non-stalled RUN cycles only.
    always_comb begin
        beat_cnt_next = '0;
        if (state_reg == S_RUN) begin
            beat_cnt_next = stall_i ? beat_cnt_reg : (beat_cnt_reg + STREAM_ONE);
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or negedge general_rst_i) begin
        if (!general_rst_i) begin
            load_cnt_reg <= '0;
            beat_cnt_reg <= '0;
        end else begin
            load_cnt_reg <= load_cnt_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    // Output decode from the state register. At most one array phase
    // signal is active at a time.
    always_comb begin
        rst_o               = 1'b0;
        load_o              = 1'b0;
        ready_o             = 1'b0;
        start_op_o          = 1'b0;
        rd_rom_signals_ld_o = 1'b0;
        rd_weight_ld_o      = 1'b0;
        rd_feature_ld_o     = 1'b0;
        done_o              = 1'b0;
        busy_o              = (state_reg != S_IDLE);
        case (state_reg)
            S_FETCH:   rd_rom_signals_ld_o = 1'b1;
            S_ARR_RST: rst_o               = 1'b1;
            S_LOAD: begin
                load_o         = 1'b1;
                rd_weight_ld_o = 1'b1;
            end
            S_READY:   ready_o             = 1'b1;
            S_RUN: begin
                start_op_o      = 1'b1;
                rd_feature_ld_o = !stall_i;
            end
            S_DONE:    done_o              = 1'b1;
            default: begin
            end
        endcase
    end

    assign addrs_rom_signal_o = addr_reg;

endmodule

// File: tb/tb_sa_group_sequencer.sv
// tb_sa_group_sequencer
// Directed bench for sa_group_sequencer. Each job is described by a
// per-cycle phase string:
//   I idle, F fetch, R array reset, L load, Y ready, U run,
//   S run with stall_i high, N next, D done.
// Every character is checked against the output pattern expected for
// that phase.
module tb_sa_group_sequencer;

    localparam int AW = 10;
    localparam int FW = 2;
    localparam int SW = 16;

    logic          clk_i = 1'b0;
    logic          general_rst_i = 1'b0;
    logic          start_i = 1'b0;
    logic [AW-1:0] num_groups_i = '0;
    logic [FW-1:0] filter_size_i = '0;
    logic [SW-1:0] stream_len_i = '0;
    logic          stall_i = 1'b0;
    logic          rst_o, load_o, ready_o, start_op_o;
    logic          rd_rom_signals_ld_o, rd_weight_ld_o, rd_feature_ld_o;
    logic [AW-1:0] addrs_rom_signal_o;
    logic          busy_o, done_o;

    int checks = 0;
    int errors = 0;

    sa_group_sequencer #(
        .N_ROWS_ARRAY(4), .N(3), .SIG_ADDRS_WIDTH(AW), .STREAM_CNT_WIDTH(SW)
    ) dut (
        .clk_i(clk_i),
        .general_rst_i(general_rst_i),
        .start_i(start_i),
        .num_groups_i(num_groups_i),
        .filter_size_i(filter_size_i),
        .stream_len_i(stream_len_i),
        .stall_i(stall_i),
        .rst_o(rst_o),
        .load_o(load_o),
        .ready_o(ready_o),
        .start_op_o(start_op_o),
        .rd_rom_signals_ld_o(rd_rom_signals_ld_o),
        .addrs_rom_signal_o(addrs_rom_signal_o),
        .rd_weight_ld_o(rd_weight_ld_o),
        .rd_feature_ld_o(rd_feature_ld_o),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    // Bit order: busy rst load ready start_op rd_rom rd_weight rd_feature done
    function automatic logic [8:0] obs_vec();
        return {busy_o, rst_o, load_o, ready_o, start_op_o,
                rd_rom_signals_ld_o, rd_weight_ld_o, rd_feature_ld_o, done_o};
    endfunction

    function automatic logic [8:0] exp_vec(input byte c);
        case (c)
            "F":     return 9'b1_0000_1000;
            "R":     return 9'b1_1000_0000;
            "L":     return 9'b1_0100_0100;
            "Y":     return 9'b1_0010_0000;
            "U":     return 9'b1_0001_0010;
            "S":     return 9'b1_0001_0000;
            "N":     return 9'b1_0000_0000;
            "D":     return 9'b1_0000_0001;
            default: return 9'b0_0000_0000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Request a job. On return the bench sits at the falling edge of
    // cycle 1, the first cycle after the start edge.
    task automatic kick(input int groups, input int f, input int l);
        @(negedge clk_i);
        num_groups_i  = AW'(groups);
        filter_size_i = FW'(f);
        stream_len_i  = SW'(l);
        start_i       = 1'b1;
        @(negedge clk_i);
        start_i       = 1'b0;
    endtask

    // Walk a phase string one cycle per character. Cycle pulse_at carries
    // a spurious start_i together with different job inputs.
    task automatic run_seq(input string tag, input string seq, input int pulse_at,
                           input int exp_rom, input int exp_wt, input int exp_ft,
                           input int exp_done);
        int  n_rom = 0, n_wt = 0, n_ft = 0, n_done = 0;
        int  exp_addr = 0;
        byte c, prev;
        prev = " ";
        for (int i = 0; i < seq.len(); i++) begin
            c = seq[i];
            if (i > 0) @(negedge clk_i);
            if (prev == "N" && c == "F") exp_addr++;
            stall_i = (c == "S");
            if (i == pulse_at) begin
                start_i = 1'b1;
                num_groups_i = AW'(7);
                filter_size_i = FW'(3);
                stream_len_i = SW'(9);
            end else begin
                start_i = 1'b0;
            end
            #1;
            check($sformatf("%s c%0d phase %s", tag, i + 1, string'(c)),
                  32'(obs_vec()), 32'(exp_vec(c)));
            check($sformatf("%s c%0d addr", tag, i + 1),
                  32'(addrs_rom_signal_o), 32'(exp_addr));
            n_rom  += int'(rd_rom_signals_ld_o);
            n_wt   += int'(rd_weight_ld_o);
            n_ft   += int'(rd_feature_ld_o);
            n_done += int'(done_o);
            prev = c;
        end
        stall_i = 1'b0;
        start_i = 1'b0;
        check($sformatf("%s rom strobes", tag), 32'(n_rom), 32'(exp_rom));
        check($sformatf("%s weight strobes", tag), 32'(n_wt), 32'(exp_wt));
        check($sformatf("%s feature strobes", tag), 32'(n_ft), 32'(exp_ft));
        check($sformatf("%s done pulses", tag), 32'(n_done), 32'(exp_done));
        $display("txn %s: cycles=%0d rom=%0d weight=%0d feature=%0d done=%0d",
                 tag, seq.len(), n_rom, n_wt, n_ft, n_done);
    endtask

    initial begin
        // Reset held, with a start request that must be ignored.
        start_i = 1'b1;
        num_groups_i = AW'(1);
        repeat (2) @(negedge clk_i);
        #1;
        check("reset outputs", 32'(obs_vec()), 32'(0));
        check("reset addr", 32'(addrs_rom_signal_o), 32'(0));
        @(negedge clk_i);
        start_i = 1'b0;
        general_rst_i = 1'b1;
        @(negedge clk_i);
        #1;
        check("post-reset idle", 32'(obs_vec()), 32'(0));

        // Basic group timing: F=3, L=5, one group; done_o in cycle 13.
        kick(1, 3, 5);
        run_seq("basic", "FRLLLYUUUUUNDI", -1, 1, 3, 5, 1);

        // Multi-group: F=2, L=4, three groups; done_o 30 cycles after the first FETCH.
        kick(3, 2, 4);
        run_seq("multi", {"FRLLYUUUUN", "FRLLYUUUUN", "FRLLYUUUUND", "I"}, -1, 3, 6, 12, 1);

        // Stall mid-RUN: F=1, L=4, three stalled cycles, so RUN lasts 7 cycles.
        kick(1, 1, 4);
        run_seq("stall_mid", "FRLYUUSSSUUNDI", -1, 1, 1, 4, 1);

        // Stall on the final beat extends RUN.
        kick(1, 1, 2);
        run_seq("stall_last", "FRLYUSUNDI", -1, 1, 1, 2, 1);

        // F=0, L=0: one LOAD cycle, READY goes straight to NEXT.
        kick(1, 0, 0);
        run_seq("f0_l0", "FRLYNDI", -1, 1, 1, 0, 1);

        // Zero groups: DONE right after start, no ROM read.
        kick(0, 2, 3);
        run_seq("groups0", "DI", -1, 0, 0, 0, 0 + 1);

        // Abort during LOAD of group 1.
        kick(2, 3, 2);
        run_seq("abort", "FRLLLYUUNFRL", -1, 2, 4, 2, 0);
        general_rst_i = 1'b0;
        #1;
        check("abort async outputs", 32'(obs_vec()), 32'(0));
        check("abort async addr", 32'(addrs_rom_signal_o), 32'(0));
        @(negedge clk_i);
        #1;
        check("abort held outputs", 32'(obs_vec()), 32'(0));
        @(negedge clk_i);
        general_rst_i = 1'b1;
        @(negedge clk_i);
        #1;
        check("abort released idle", 32'(obs_vec()), 32'(0));

        // Restart from group 0. A start pulse while busy must not disturb the job.
        kick(1, 1, 1);
        run_seq("restart", "FRLYUNDII", 2, 1, 1, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
